// File: rtl/ctrl_pkg.sv
// Shared definitions for the MIPS32 control pipeline: bundle layout, opcode/funct
// constants, ALU encodings and the mul/div sequencer state type.
package ctrl_pkg;

  localparam int unsigned CTRL_W = 21;

  // Bundle bit positions, LSB first
  localparam int unsigned B_ALU_LSB     = 0;
  localparam int unsigned ALU_W         = 3;
  localparam int unsigned B_ZEXT        = 3;
  localparam int unsigned B_MULDIV      = 4;
  localparam int unsigned B_JR          = 5;
  localparam int unsigned B_DM_LOAD     = 6;
  localparam int unsigned B_JAL_WD      = 7;
  localparam int unsigned B_WR_RA_INSTR = 8;
  localparam int unsigned B_WR_RA_JAL   = 9;
  localparam int unsigned B_ALU_SRC_IMM = 10;
  localparam int unsigned B_MUL0_DIV1   = 11;
  localparam int unsigned B_HI0_LO1     = 12;
  localparam int unsigned B_HILO_MOV    = 13;
  localparam int unsigned B_ARITH       = 14;
  localparam int unsigned B_SLT         = 15;
  localparam int unsigned B_WE_DM       = 16;
  localparam int unsigned B_WE_REG      = 17;
  localparam int unsigned B_JUMP        = 18;
  localparam int unsigned B_BRANCH      = 19;
  localparam int unsigned B_ILLEGAL     = 20;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } md_state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SLL    = 6'b000000;
  localparam logic [5:0] F_JR     = 6'b001000;
  localparam logic [5:0] F_MFHI   = 6'b010000;
  localparam logic [5:0] F_MFLO   = 6'b010010;
  localparam logic [5:0] F_MULT   = 6'b011000;
  localparam logic [5:0] F_MULTU  = 6'b011001;
  localparam logic [5:0] F_DIV    = 6'b011010;
  localparam logic [5:0] F_DIVU   = 6'b011011;
  localparam logic [5:0] F_ADD    = 6'b100000;
  localparam logic [5:0] F_SUB    = 6'b100010;
  localparam logic [5:0] F_AND    = 6'b100100;
  localparam logic [5:0] F_OR     = 6'b100101;
  localparam logic [5:0] F_SLT    = 6'b101010;

endpackage

// File: rtl/ctrl_pipe_unit_decode.sv
// Combinational opcode/funct decode into the control bundle.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  output logic [CTRL_W-1:0] ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_SLL: begin
            // only sll $0 reaches here in practice; treated as NOP
          end
          F_ADD: begin
            ctrl[B_ALU_LSB +: ALU_W] = ALU_ADD;
            ctrl[B_WR_RA_INSTR] = 1'b1;
            ctrl[B_ARITH]       = 1'b1;
            ctrl[B_WE_REG]      = 1'b1;
          end
          F_SUB: begin
            ctrl[B_ALU_LSB +: ALU_W] = ALU_SUB;
            ctrl[B_WR_RA_INSTR] = 1'b1;
            ctrl[B_ARITH]       = 1'b1;
            ctrl[B_WE_REG]      = 1'b1;
          end
          F_AND: begin
            ctrl[B_ALU_LSB +: ALU_W] = ALU_AND;
            ctrl[B_WR_RA_INSTR] = 1'b1;
            ctrl[B_WE_REG]      = 1'b1;
          end
          F_OR: begin
            ctrl[B_ALU_LSB +: ALU_W] = ALU_OR;
            ctrl[B_WR_RA_INSTR] = 1'b1;
            ctrl[B_WE_REG]      = 1'b1;
          end
          F_SLT: begin
            ctrl[B_ALU_LSB +: ALU_W] = ALU_SLT;
            ctrl[B_WR_RA_INSTR] = 1'b1;
            ctrl[B_SLT]         = 1'b1;
            ctrl[B_WE_REG]      = 1'b1;
          end
          F_JR: ctrl[B_JR] = 1'b1;
          F_MULT, F_MULTU: ctrl[B_MULDIV] = 1'b1;
          F_DIV, F_DIVU: begin
            ctrl[B_MULDIV]    = 1'b1;
            ctrl[B_MUL0_DIV1] = 1'b1;
          end
          F_MFHI, F_MFLO: begin
            ctrl[B_HILO_MOV]    = 1'b1;
            ctrl[B_HI0_LO1]     = (funct == F_MFLO);
            ctrl[B_WR_RA_INSTR] = 1'b1;
            ctrl[B_WE_REG]      = 1'b1;
          end
          default: ctrl[B_ILLEGAL] = 1'b1;
        endcase
      end
      OP_LW: begin
        ctrl[B_ALU_LSB +: ALU_W] = ALU_ADD;
        ctrl[B_ALU_SRC_IMM] = 1'b1;
        ctrl[B_DM_LOAD]     = 1'b1;
        ctrl[B_WE_REG]      = 1'b1;
      end
      OP_SW: begin
        ctrl[B_ALU_LSB +: ALU_W] = ALU_ADD;
        ctrl[B_ALU_SRC_IMM] = 1'b1;
        ctrl[B_WE_DM]       = 1'b1;
      end
      OP_BEQ: begin
        ctrl[B_ALU_LSB +: ALU_W] = ALU_SUB;
        ctrl[B_BRANCH] = 1'b1;
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl[B_ALU_LSB +: ALU_W] = ALU_ADD;
        ctrl[B_ALU_SRC_IMM] = 1'b1;
        ctrl[B_ARITH]       = (opcode == OP_ADDI);
        ctrl[B_WE_REG]      = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        ctrl[B_ALU_LSB +: ALU_W] = (opcode == OP_ORI) ? ALU_OR : ALU_AND;
        ctrl[B_ZEXT]        = 1'b1;
        ctrl[B_ALU_SRC_IMM] = 1'b1;
        ctrl[B_WE_REG]      = 1'b1;
      end
      OP_SLTI: begin
        ctrl[B_ALU_LSB +: ALU_W] = ALU_SLT;
        ctrl[B_ALU_SRC_IMM] = 1'b1;
        ctrl[B_SLT]         = 1'b1;
        ctrl[B_WE_REG]      = 1'b1;
      end
      OP_J: ctrl[B_JUMP] = 1'b1;
      OP_JAL: begin
        ctrl[B_JUMP]      = 1'b1;
        ctrl[B_JAL_WD]    = 1'b1;
        ctrl[B_WR_RA_JAL] = 1'b1;
        ctrl[B_WE_REG]    = 1'b1;
      end
      default: ctrl[B_ILLEGAL] = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Control pipeline: ID decode, NUM_STAGES registered control slots with bubble
// insertion, and the mul/div busy sequencer driving the HI/LO hazard stall.
module ctrl_pipe_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned MUL_LAT    = 4,
  parameter int unsigned DIV_LAT    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [5:0]                   opcode,
  input  logic [5:0]                   funct,
  input  logic                         stall,
  input  logic                         flush,
  output logic [CTRL_W-1:0]            id_ctrl,
  output logic [NUM_STAGES*CTRL_W-1:0] stage_ctrl,
  output logic                         id_stall,
  output logic                         md_busy,
  output logic                         md_start,
  output logic                         md_done
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
  localparam logic MUL_ONE = (MUL_LAT == 1);
  localparam logic DIV_ONE = (DIV_LAT == 1);

  logic [CTRL_W-1:0] slot_q [NUM_STAGES];
  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hazard_stall;
  logic              done_c;
  logic              div_sel;

  ctrl_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .ctrl   (id_ctrl)
  );

  assign md_busy      = (state_q == MD_BUSY);
  assign hazard_stall = md_busy & (id_ctrl[B_HILO_MOV] | id_ctrl[B_MULDIV]);
  assign id_stall     = stall | hazard_stall;
  assign md_start     = slot_q[0][B_MULDIV];
  assign div_sel      = slot_q[0][B_MUL0_DIV1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_STAGES; k++) slot_q[k] <= '0;
    end else begin
      slot_q[0] <= (flush || id_stall) ? '0 : id_ctrl;
      for (int unsigned k = 1; k < NUM_STAGES; k++) slot_q[k] <= slot_q[k-1];
    end
  end

  always_comb begin
    stage_ctrl = '0;
    for (int unsigned k = 0; k < NUM_STAGES; k++)
      stage_ctrl[k*CTRL_W +: CTRL_W] = slot_q[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Single-cycle latency completes in the start cycle without entering BUSY
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_c  = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (md_start) begin
          if (div_sel ? DIV_ONE : MUL_ONE) begin
            done_c = 1'b1;
          end else begin
            state_d = MD_BUSY;
            cnt_d   = div_sel ? DIV_CNT : MUL_CNT;
          end
        end
      end
      MD_BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          done_c  = 1'b1;
          state_d = MD_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign md_done = done_c & ~rst;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed bench for ctrl_pipe_unit: default instance plus a MUL_LAT=1 instance
// sharing the same ID stream.
module tb_ctrl_pipe_unit;

  localparam int W = 21;

  localparam logic [W-1:0] C_ADD  = 21'h024102;
  localparam logic [W-1:0] C_LW   = 21'h020442;
  localparam logic [W-1:0] C_ORI  = 21'h020409;
  localparam logic [W-1:0] C_JAL  = 21'h060280;
  localparam logic [W-1:0] C_BEQ  = 21'h080006;
  localparam logic [W-1:0] C_MFHI = 21'h022100;
  localparam logic [W-1:0] C_MFLO = 21'h023100;
  localparam logic [W-1:0] C_MULT = 21'h000010;
  localparam logic [W-1:0] C_DIV  = 21'h000810;
  localparam logic [W-1:0] C_ILL  = 21'h100000;

  logic clk = 1'b0;
  logic rst, stall, flush;
  logic [5:0] opcode, funct;

  logic [W-1:0]   d0_id, d1_id;
  logic [3*W-1:0] d0_stage, d1_stage;
  logic d0_idst, d0_busy, d0_start, d0_done;
  logic d1_idst, d1_busy, d1_start, d1_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctrl_pipe_unit dut0 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .stall(stall), .flush(flush),
    .id_ctrl(d0_id), .stage_ctrl(d0_stage), .id_stall(d0_idst),
    .md_busy(d0_busy), .md_start(d0_start), .md_done(d0_done)
  );

  ctrl_pipe_unit #(.NUM_STAGES(3), .MUL_LAT(1), .DIV_LAT(32)) dut1 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .stall(stall), .flush(flush),
    .id_ctrl(d1_id), .stage_ctrl(d1_stage), .id_stall(d1_idst),
    .md_busy(d1_busy), .md_start(d1_start), .md_done(d1_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
    #1;
  endtask

  typedef struct {
    string        tag;
    logic [5:0]   op;
    logic [5:0]   fn;
    logic [W-1:0] exp;
  } dec_vec_t;

  dec_vec_t dec_tab [11];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, done_cnt, done_at, stall_cnt, bubbles;
    logic found, was_stall;

    dec_tab[0]  = '{"dec_ori",   6'b001101, 6'b000000, C_ORI};
    dec_tab[1]  = '{"dec_jal",   6'b000011, 6'b000000, C_JAL};
    dec_tab[2]  = '{"dec_beq",   6'b000100, 6'b000000, C_BEQ};
    dec_tab[3]  = '{"dec_lw",    6'b100011, 6'b000000, C_LW};
    dec_tab[4]  = '{"dec_mfhi",  6'b000000, 6'b010000, C_MFHI};
    dec_tab[5]  = '{"dec_mflo",  6'b000000, 6'b010010, C_MFLO};
    dec_tab[6]  = '{"dec_mult",  6'b000000, 6'b011000, C_MULT};
    dec_tab[7]  = '{"dec_divu",  6'b000000, 6'b011011, C_DIV};
    dec_tab[8]  = '{"dec_nop",   6'b000000, 6'b000000, 21'h0};
    dec_tab[9]  = '{"dec_badfn", 6'b000000, 6'b111111, C_ILL};
    dec_tab[10] = '{"dec_badop", 6'b111111, 6'b000000, C_ILL};

    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_id(6'b000000, 6'b100000);
    tick; tick;
    check("rst_stage", 64'(d0_stage), 64'h0);
    check("rst_busy",  64'(d0_busy),  64'h0);
    check("rst_start", 64'(d0_start), 64'h0);
    check("rst_done",  64'(d0_done),  64'h0);
    check("id_add",    64'(d0_id),    64'(C_ADD));

    rst = 1'b0;
    tick;
    check("add_slot0", 64'(d0_stage[0 +: W]), 64'(C_ADD));
    check("add_slot1_pre", 64'(d0_stage[W +: W]), 64'h0);
    tick; tick;
    check("add_slot2", 64'(d0_stage[2*W +: W]), 64'(C_ADD));

    foreach (dec_tab[i]) begin
      set_id(dec_tab[i].op, dec_tab[i].fn);
      check(dec_tab[i].tag, 64'(d0_id), 64'(dec_tab[i].exp));
    end

    // flush and stall together with lw in ID; prior add advances
    set_id(6'b000000, 6'b100000);
    tick;
    set_id(6'b100011, 6'b000000);
    stall = 1'b1; flush = 1'b1;
    #1;
    check("stall_idst", 64'(d0_idst), 64'h1);
    tick;
    check("flush_slot0", 64'(d0_stage[0 +: W]), 64'h0);
    check("flush_slot1", 64'(d0_stage[W +: W]), 64'(C_ADD));
    stall = 1'b0; flush = 1'b0;

    set_id(6'b111111, 6'b000000);
    tick;
    check("ill_slot0", 64'(d0_stage[0 +: W]), 64'(C_ILL));
    tick; tick;
    check("ill_slot2", 64'(d0_stage[2*W +: W]), 64'(C_ILL));
    set_id(6'b000000, 6'b000000);
    tick; tick; tick;

    // div, nop, then mflo waiting on HI/LO
    set_id(6'b000000, 6'b011010);
    tick;
    check("div_start", 64'(d0_start), 64'h1);
    check("div_busy0", 64'(d0_busy),  64'h0);
    check("div_done0", 64'(d0_done),  64'h0);
    set_id(6'b000000, 6'b000000);
    tick;
    set_id(6'b000000, 6'b010010);
    busy_cnt = 0; done_cnt = 0; done_at = -1; stall_cnt = 0; bubbles = 0; found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (d0_busy) busy_cnt++;
      if (d0_done) begin done_cnt++; done_at = busy_cnt; end
      if (d0_idst) stall_cnt++;
      was_stall = d0_idst;
      tick;
      if (was_stall && d0_stage[0 +: W] == '0) bubbles++;
      if (d0_stage[0 +: W] == C_MFLO) found = 1'b1;
    end
    check("div_busy_cycles", 64'(busy_cnt),  64'd31);
    check("div_stall_cycles", 64'(stall_cnt), 64'd31);
    check("div_bubbles",     64'(bubbles),   64'd31);
    check("div_done_count",  64'(done_cnt),  64'd1);
    check("div_done_at",     64'(done_at),   64'd31);
    check("mflo_in_ex",      64'(found),     64'h1);
    check("div_busy_after",  64'(d0_busy),   64'h0);
    set_id(6'b000000, 6'b000000);
    tick; tick; tick; tick;

    // MUL_LAT=1 instance: start and done coincide, no busy, no stall
    set_id(6'b000000, 6'b011000);
    tick;
    check("mul1_start", 64'(d1_start), 64'h1);
    check("mul1_done",  64'(d1_done),  64'h1);
    check("mul1_busy",  64'(d1_busy),  64'h0);
    set_id(6'b000000, 6'b010000);
    check("mul1_nostall", 64'(d1_idst), 64'h0);
    tick;
    check("mul1_busy_next", 64'(d1_busy), 64'h0);
    check("mul1_mfhi_ex", 64'(d1_stage[0 +: W]), 64'(C_MFHI));
    set_id(6'b000000, 6'b000000);
    repeat (6) tick;

    // reset in BUSY cycle 10 of a div
    set_id(6'b000000, 6'b011010);
    tick;
    set_id(6'b000000, 6'b000000);
    repeat (9) tick;
    check("midbusy_busy", 64'(d0_busy), 64'h1);
    rst = 1'b1;
    #1;
    check("midbusy_rst_done", 64'(d0_done), 64'h0);
    tick;
    check("midbusy_abort", 64'(d0_busy), 64'h0);
    check("midbusy_stage", 64'(d0_stage), 64'h0);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (d0_done) done_cnt++;
      tick;
    end
    check("midbusy_no_done", 64'(done_cnt), 64'd0);

    set_id(6'b000000, 6'b011010);
    tick;
    check("restart_start", 64'(d0_start), 64'h1);
    set_id(6'b000000, 6'b000000);
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (d0_busy) busy_cnt++;
      if (d0_done) done_cnt++;
      tick;
    end
    check("restart_busy_cycles", 64'(busy_cnt), 64'd31);
    check("restart_done_count",  64'(done_cnt), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_unit.md
Name: ctrl_pipe_unit

Overview:
- Parametrised successor to the single-cycle MIPS32 control decode.
- Decodes opcode/funct in ID and carries the decoded control bundle through NUM_STAGES registered stages (slot 0 = EX, 1 = MEM, 2 = WB, ...).
- Adds stall and flush bubble insertion, plus a mul/div busy sequencer that raises an HI/LO hazard stall.
- Sits between the IF/ID register and the datapath; the hazard unit consumes id_stall.

Parameters:
- NUM_STAGES, 3, number of registered control stages after ID (minimum 1).
- MUL_LAT, 4, cycles from mult/multu in EX until HI/LO valid (minimum 1).
- DIV_LAT, 32, cycles from div/divu in EX until HI/LO valid (minimum 1).
- CTRL_W, 21, bundle width; fixed by the package, not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- opcode  in  6  instr[31:26] in ID
- funct  in  6  instr[5:0] in ID
- stall  in  1  external stall: hold ID, insert bubble into EX
- flush  in  1  kill the ID instruction (bubble into EX)
- id_ctrl  out  CTRL_W  combinational decode of the ID instruction
- stage_ctrl  out  NUM_STAGES*CTRL_W  registered bundles; slot k at bits [k*CTRL_W +: CTRL_W]
- id_stall  out  1  stall | hazard_stall
- md_busy  out  1  mul/div sequencer in BUSY
- md_start  out  1  pulse: mul/div instruction in EX this cycle
- md_done  out  1  pulse: HI/LO result valid

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: every stage_ctrl slot = 0 (NOP), FSM = IDLE, counter = 0, md_busy/md_start/md_done = 0.
- Reset mid-operation aborts any BUSY count immediately and produces no md_done.
- Bundle field order, LSB first: alu_ctrl[2:0], signExt0_zeroExt1, muldiv_op, jr_sel, dm_load_op, jal_wd_sel, wr_ra_instr, wr_ra_jal, alu_src_imm, mul0_div1_sel, hi0_lo1_sel, hilo_mov_op, arith_op, slt_op, we_dm, we_reg, jump, branch, illegal.
- alu_ctrl encodings: and=000, or=001, add=010, sub=110, slt=111.
- Decode set:
  - R-type (funct): add, sub, and, or, slt, jr, mult, multu, div, divu, mfhi, mflo.
  - I/J-type: lw, sw, beq, addi, addiu, andi, ori (zero-extended), slti, j, jal.
- Unknown opcode, or R-type with unknown funct: bundle = 0 except illegal = 1.
- An all-zero instruction word (sll $0) decodes as NOP with illegal = 0.
- Slot 0 next-state priority: rst > flush > (stall | hazard_stall) → zero bubble > id_ctrl.
- Slots k ≥ 1 always load slot k−1. Stalls never freeze EX and beyond.
- A muldiv_op in slot 0 pulses md_start that cycle. Let L be MUL_LAT or DIV_LAT, chosen by mul0_div1_sel.
  - L = 1: md_done pulses in the same cycle as md_start; FSM stays IDLE.
  - L ≥ 2: FSM goes IDLE → BUSY with counter = L−1, then decrements each cycle.
  - In BUSY with counter == 1: md_done pulses and FSM returns to IDLE on the next edge.
  - md_busy is high for exactly L−1 cycles.
- hazard_stall = md_busy & (id_ctrl.hilo_mov_op | id_ctrl.muldiv_op).
- A new muldiv can never reach EX while BUSY.
- hazard_stall is evaluated on the ID instruction even while flush is high; flush still wins for slot 0.
- Latency: id_ctrl reaches slot k after k+1 edges when unstalled.

Decomposition:
- Package ctrl_pkg holds:
  - CTRL_W and the bit-index localparams for every bundle field;
  - opcode/funct constants;
  - alu_ctrl encodings.
- Sub-module ctrl_decode: purely combinational opcode/funct → bundle.
- ctrl_pipe_unit owns the stage registers, the muldiv FSM/counter and the stall logic.

Test Plan:
- Reset: assert rst 2 cycles while feeding add → all stage_ctrl = 0, md_* = 0. Release → add bundle (we_reg=1, alu_ctrl=010, arith_op=1) in slot 0 after 1 edge and slot 2 after 3 edges.
- DIV_LAT=32: div then mflo back-to-back.
  - div in EX → md_start=1, md_busy high for 31 cycles, md_done at the 31st BUSY cycle.
  - mflo held in ID with id_stall=1 for 31 cycles, 31 bubbles in slot 0, then the mflo bundle enters EX.
- MUL_LAT=1: mult then mfhi → md_start and md_done pulse together, md_busy never high, no stall.
- Flush with lw in ID and stall=1 simultaneously → slot 0 = 0, the prior slot-0 bundle advances to slot 1.
- Opcode 111111 → id_ctrl illegal=1, all other fields 0; illegal propagates to slot NUM_STAGES−1.
- Reset asserted mid-BUSY (cycle 10 of a div) → md_busy=0 on the next edge, no md_done, and a subsequent div restarts the full 31-cycle count.
